// File: rtl/io_cell_cfg_ctrl.sv
// Configuration controller for the IO cell frame: per-cell shadow registers behind a
// request/grant register port, atomically committed to the active cell_cfg bus.
module io_cell_cfg_ctrl #(
  parameter int unsigned                IOCELL_CFG_W = 5,
  parameter int unsigned                IOCELL_COUNT = 28,
  parameter int unsigned                ADDR_W       = 8,
  parameter logic [IOCELL_CFG_W-1:0]    RESET_CFG    = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_i,
  input  logic                                 we_i,
  input  logic [ADDR_W-1:0]                    addr_i,
  input  logic [31:0]                          wdata_i,
  output logic                                 gnt_o,
  output logic                                 rvalid_o,
  output logic [31:0]                          rdata_o,
  output logic                                 err_o,
  output logic                                 commit_done_o,
  output logic [IOCELL_CFG_W*IOCELL_COUNT-1:0] cell_cfg
);

  localparam int unsigned       IDX_W       = (IOCELL_COUNT > 1) ? $clog2(IOCELL_COUNT) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(IOCELL_COUNT);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(IOCELL_COUNT + 1);

  typedef logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] cfg_bank_t;

  cfg_bank_t   shadow_q;
  cfg_bank_t   active_q;
  logic        pending_q;
  logic        locked_q;
  logic        err_sticky_q;
  logic        rvalid_q;
  logic        err_q;
  logic        commit_done_q;
  logic [31:0] rdata_q;

  logic              hit_shadow;
  logic              hit_ctrl;
  logic              hit_status;
  logic              access_err;
  logic              wr_shadow;
  logic              wr_ctrl;
  logic              do_commit;
  logic              do_lock;
  logic              err_clear;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rdata_next;

  assign gnt_o = req_i;

  assign hit_shadow = (addr_i < CTRL_ADDR);
  assign hit_ctrl   = (addr_i == CTRL_ADDR);
  assign hit_status = (addr_i == STATUS_ADDR);
  assign idx        = addr_i[IDX_W-1:0];

  // Out-of-range addresses always fault; a locked block also rejects config writes.
  assign access_err = !(hit_shadow || hit_ctrl || hit_status) ||
                      (we_i && locked_q && (hit_shadow || hit_ctrl));

  assign wr_shadow = req_i && we_i && hit_shadow && !locked_q;
  assign wr_ctrl   = req_i && we_i && hit_ctrl   && !locked_q;
  assign do_commit = wr_ctrl && wdata_i[0];
  assign do_lock   = wr_ctrl && wdata_i[1];
  assign err_clear = req_i && we_i && hit_status && wdata_i[2];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    rdata_next = '0;
    if (req_i && !we_i && !access_err) begin
      if (hit_shadow) begin
        rdata_next = 32'(shadow_q[idx]);
      end else if (hit_status) begin
        rdata_next = {29'b0, err_sticky_q, locked_q, pending_q};
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow bank is plain flops, so it is reset like any other register.
      shadow_q      <= {IOCELL_COUNT{RESET_CFG}};
      active_q      <= {IOCELL_COUNT{RESET_CFG}};
      pending_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_sticky_q  <= 1'b0;
      rvalid_q      <= 1'b0;
      err_q         <= 1'b0;
      commit_done_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      rvalid_q      <= req_i;
      err_q         <= req_i && access_err;
      rdata_q       <= rdata_next;
      commit_done_q <= do_commit;

      if (wr_shadow) begin
        shadow_q[idx] <= wdata_i[IOCELL_CFG_W-1:0];
        pending_q     <= 1'b1;
      end

      // Commit and lock in one write: the copy uses the unlocked shadows of this edge.
      if (do_commit) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      if (do_lock) begin
        locked_q <= 1'b1;
      end

      if (req_i && access_err) begin
        err_sticky_q <= 1'b1;
      end else if (err_clear) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign commit_done_o = commit_done_q;
  assign cell_cfg      = active_q;

endmodule
